trace_cmd_dispatch: RTL and testbench
=====================================

TRACE_CMD_DISPATCH -- requirements
Module: trace_cmd_dispatch

Interface
REQ-001 Parameter ADDRESS_BITS, default 32: trace address width.
REQ-002 Parameter OFFSET_BITS, default 6: byte-select width (64 B line).
REQ-003 Parameter INDEX_BITS, default 14: set index width; TAG_BITS = ADDRESS_BITS-INDEX_BITS-OFFSET_BITS (12).
REQ-004 Parameter DEPTH, default 4: FIFO entries, power of two, >=2.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low. Ports are clk and rst_n.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 in_valid  in  1  trace record present.
REQ-009 in_ready  out  1  block accepts record this cycle.
REQ-010 in_cmd  in  4  trace command code.
REQ-011 in_addr  in  ADDRESS_BITS  trace address.
REQ-012 out_valid  out  1  decoded request available to cache.
REQ-013 out_ready  in  1  cache consumes request this cycle.
REQ-014 out_cmd  out  4  command of head entry.
REQ-015 out_tag / out_index / out_offset  out  TAG_BITS / INDEX_BITS / OFFSET_BITS  address fields of head entry.
REQ-016 out_class  out  2  0=data (READ/WRITE), 1=inst (I_FETCH), 2=snoop (L2_INVAL/L2_DATA_RQ), 3=control (CLR/PRINT).
REQ-017 fill_level  out  $clog2(DEPTH)+1  entries held.
REQ-018 rd_cnt, wr_cnt, if_cnt, bad_cnt  out  16 each  dispatched READ, WRITE, I_FETCH counts; rejected-code count.

Function
REQ-019 Legal codes: READ=0, WRITE=1, I_FETCH=2, L2_INVAL=3, L2_DATA_RQ=4, CLR=8, PRINT=9; all others illegal.
REQ-020 in_ready SHALL equal (fill_level != DEPTH); no same-cycle bypass when full, even if a pop occurs.
REQ-021 Accept = in_valid & in_ready; a legal accepted record is written at the tail on that edge.
REQ-022 An illegal accepted record SHALL NOT enter the FIFO; bad_cnt increments by 1 on that edge.
REQ-023 out_valid SHALL equal (fill_level != 0); out_* fields are driven from the head entry.
REQ-024 Latency: record accepted at edge N is visible at the output from edge N onward if FIFO was empty (one-cycle insertion, no combinational in->out path).
REQ-025 Pop = out_valid & out_ready; head advances on that edge; out_* SHALL hold stable while out_valid & !out_ready.
REQ-026 Simultaneous push and pop: fill_level unchanged, both pointers advance.
REQ-027 Pointers SHALL wrap modulo DEPTH; order is strictly FIFO.
REQ-028 On pop: READ -> rd_cnt+1, WRITE -> wr_cnt+1, I_FETCH -> if_cnt+1.
REQ-029 On pop of CLR: rd_cnt, wr_cnt, if_cnt, bad_cnt SHALL become 0 on that edge; a same-edge bad_cnt increment is lost (clear wins).
REQ-030 All counters SHALL saturate at 16'hFFFF.
REQ-031 Field split: offset=addr[OFFSET_BITS-1:0], index=addr[OFFSET_BITS+:INDEX_BITS], tag=addr[ADDRESS_BITS-1:OFFSET_BITS+INDEX_BITS].
REQ-032 PRINT, L2_INVAL, and L2_DATA_RQ are passed through unchanged; no counter effect.

Reset
REQ-033 With rst_n low at a rising edge: pointers and fill_level 0, all counters 0, out_valid 0, in_ready 1 on the following cycle.
REQ-034 Reset mid-operation SHALL discard all entries; no pop or push is recorded on the reset edge.
REQ-035 out_* data fields are don't-care while out_valid=0.

Verification
REQ-036 READ 0x12345678, out_ready=1 -> next cycle out_tag=0x123, out_index=0x1159, out_offset=0x38, out_class=0; after pop, rd_cnt=1.
REQ-037 Push 5 legal records, out_ready=0 -> in_ready=0 after 4th; fill_level=4; 5th held; release -> 5 records emerge in order.
REQ-038 in_cmd=7 then in_cmd=15 -> FIFO stays empty, bad_cnt=2, out_valid never asserted.
REQ-039 WRITE, I_FETCH, CLR, READ popped back-to-back -> after CLR pop all counters 0; final rd_cnt=1, wr_cnt=0, if_cnt=0.
REQ-040 FIFO at 2 entries, simultaneous push and pop for 10 cycles -> fill_level stays 2, pointer wrap, order preserved.
REQ-041 rst_n low with 3 entries queued -> next cycle fill_level=0, out_valid=0, counters 0, in_ready=1.

Source files
------------

// File: rtl/trace_cmd_dispatch.sv
// Purpose : decode trace command records and queue them for the cache model,
//           keeping per-type dispatch counters and a count of rejected codes.
// Latency : a record accepted on edge N is presented at the head from edge N on
//           (registered insertion, no combinational in->out path).
// Backpr. : in_ready drops when the queue is full, even if a pop happens in the
//           same cycle; out_* hold stable while out_valid & !out_ready.
// Ports   : clk, rst_n (sync, active-low); in_valid/in_ready/in_cmd/in_addr;
//           out_valid/out_ready/out_cmd/out_tag/out_index/out_offset/out_class;
//           fill_level; rd_cnt/wr_cnt/if_cnt/bad_cnt (16-bit, saturating).
module trace_cmd_dispatch #(
  parameter int ADDRESS_BITS = 32,
  parameter int OFFSET_BITS  = 6,
  parameter int INDEX_BITS   = 14,
  parameter int DEPTH        = 4,
  localparam int TAG_BITS    = ADDRESS_BITS - INDEX_BITS - OFFSET_BITS,
  localparam int PTR_BITS    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_cmd,
  input  logic [ADDRESS_BITS-1:0] in_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_cmd,
  output logic [TAG_BITS-1:0]     out_tag,
  output logic [INDEX_BITS-1:0]   out_index,
  output logic [OFFSET_BITS-1:0]  out_offset,
  output logic [1:0]              out_class,
  output logic [PTR_BITS:0]       fill_level,
  output logic [15:0]             rd_cnt,
  output logic [15:0]             wr_cnt,
  output logic [15:0]             if_cnt,
  output logic [15:0]             bad_cnt
);

  localparam logic [3:0] CMD_READ    = 4'd0;
  localparam logic [3:0] CMD_WRITE   = 4'd1;
  localparam logic [3:0] CMD_I_FETCH = 4'd2;
  localparam logic [3:0] CMD_L2_INV  = 4'd3;
  localparam logic [3:0] CMD_L2_DRQ  = 4'd4;
  localparam logic [3:0] CMD_CLR     = 4'd8;
  localparam logic [3:0] CMD_PRINT   = 4'd9;

  localparam logic [PTR_BITS:0] FULL_LEVEL = (PTR_BITS+1)'(DEPTH);

  logic [3:0]              cmd_mem  [DEPTH];
  logic [ADDRESS_BITS-1:0] addr_mem [DEPTH];
  logic [PTR_BITS-1:0]     wr_ptr;
  logic [PTR_BITS-1:0]     rd_ptr;
  logic [ADDRESS_BITS-1:0] head_addr;

  logic accept, push, pop, in_legal;

  function automatic logic is_legal(input logic [3:0] c);
    case (c)
      CMD_READ, CMD_WRITE, CMD_I_FETCH, CMD_L2_INV, CMD_L2_DRQ,
      CMD_CLR, CMD_PRINT: is_legal = 1'b1;
      default:            is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign in_ready  = (fill_level != FULL_LEVEL);
  assign out_valid = (fill_level != '0);
  assign in_legal  = is_legal(in_cmd);
  assign accept    = in_valid & in_ready;
  assign push      = accept & in_legal;
  assign pop       = out_valid & out_ready;

  assign out_cmd    = cmd_mem[rd_ptr];
  assign head_addr  = addr_mem[rd_ptr];
  assign out_offset = head_addr[OFFSET_BITS-1:0];
  assign out_index  = head_addr[OFFSET_BITS +: INDEX_BITS];
  assign out_tag    = head_addr[ADDRESS_BITS-1 : OFFSET_BITS+INDEX_BITS];

  always_comb begin
    out_class = 2'd3;
    case (out_cmd)
      CMD_READ, CMD_WRITE:   out_class = 2'd0;
      CMD_I_FETCH:           out_class = 2'd1;
      CMD_L2_INV, CMD_L2_DRQ: out_class = 2'd2;
      default:               out_class = 2'd3;
    endcase
  end

  // Payload storage needs no reset: contents are only observed while valid.
  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[wr_ptr]  <= in_cmd;
      addr_mem[wr_ptr] <= in_addr;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   fill_level <= fill_level + (PTR_BITS+1)'(1);
        2'b01:   fill_level <= fill_level - (PTR_BITS+1)'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Popping CLR wipes every counter, including a bad_cnt bump on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      if_cnt  <= '0;
      bad_cnt <= '0;
    end else if (pop && out_cmd == CMD_CLR) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      if_cnt  <= '0;
      bad_cnt <= '0;
    end else begin
      if (pop && out_cmd == CMD_READ)    rd_cnt <= sat_inc(rd_cnt);
      if (pop && out_cmd == CMD_WRITE)   wr_cnt <= sat_inc(wr_cnt);
      if (pop && out_cmd == CMD_I_FETCH) if_cnt <= sat_inc(if_cnt);
      if (accept && !in_legal)           bad_cnt <= sat_inc(bad_cnt);
    end
  end

endmodule

// File: tb/tb_trace_cmd_dispatch.sv
module tb_trace_cmd_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cmd;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_cmd;
  logic [11:0] out_tag;
  logic [13:0] out_index;
  logic [5:0]  out_offset;
  logic [1:0]  out_class;
  logic [2:0]  fill_level;
  logic [15:0] rd_cnt, wr_cnt, if_cnt, bad_cnt;

  int checks = 0;
  int errors = 0;

  trace_cmd_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
    .out_tag(out_tag), .out_index(out_index), .out_offset(out_offset),
    .out_class(out_class), .fill_level(fill_level),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .if_cnt(if_cnt), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_cmd = 4'd0; in_addr = 32'd0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("rst_fill",     32'(fill_level), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready",  32'(in_ready), 1);
    check("rst_counters",  {16'(rd_cnt | wr_cnt), 16'(if_cnt | bad_cnt)}, 0);

    // Single READ: field split and dispatch count.
    out_ready = 1'b1;
    in_valid = 1'b1; in_cmd = 4'd0; in_addr = 32'h12345678;
    step();
    in_valid = 1'b0;
    check("rd_out_valid", 32'(out_valid), 1);
    check("rd_tag",       32'(out_tag), 32'h123);
    check("rd_index",     32'(out_index), 32'h1159);
    check("rd_offset",    32'(out_offset), 32'h38);
    check("rd_class",     32'(out_class), 0);
    step();
    check("rd_cnt_after_pop", 32'(rd_cnt), 1);
    check("rd_fill_after_pop", 32'(fill_level), 0);

    // Illegal codes are counted and dropped.
    out_ready = 1'b0;
    in_valid = 1'b1; in_cmd = 4'd7;
    step();
    check("bad7_out_valid", 32'(out_valid), 0);
    check("bad7_cnt",       32'(bad_cnt), 1);
    in_cmd = 4'd15;
    step();
    in_valid = 1'b0;
    check("bad15_out_valid", 32'(out_valid), 0);
    check("bad15_cnt",       32'(bad_cnt), 2);
    check("bad15_fill",      32'(fill_level), 0);

    // Fill to full: cmds 0..3, tag and offset equal to the index.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_cmd = 4'(i); in_addr = (32'(i) << 20) | 32'(i);
      step();
    end
    check("full_fill",     32'(fill_level), 4);
    check("full_in_ready", 32'(in_ready), 0);
    in_cmd = 4'd4; in_addr = (32'd4 << 20) | 32'd4;
    step();
    check("full_hold_fill", 32'(fill_level), 4);
    check("full_hold_cmd",  32'(out_cmd), 0);
    check("full_hold_tag",  32'(out_tag), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k <= 1);
      check($sformatf("order_cmd%0d", k), 32'(out_cmd), 32'(k));
      check($sformatf("order_off%0d", k), 32'(out_offset), 32'(k));
      check($sformatf("order_tag%0d", k), 32'(out_tag), 32'(k));
      if (k == 3) check("class_snoop", 32'(out_class), 2);
      step();
      if (k == 0) check("order_fill_after_pop", 32'(fill_level), 3);
      if (k == 1) check("order_fill_push_pop", 32'(fill_level), 3);
    end
    in_valid = 1'b0;
    check("order_empty", 32'(out_valid), 0);
    check("order_rd_cnt", 32'(rd_cnt), 2);
    check("order_wr_cnt", 32'(wr_cnt), 1);
    check("order_if_cnt", 32'(if_cnt), 1);
    check("order_bad_cnt", 32'(bad_cnt), 2);

    // WRITE, I_FETCH, CLR, READ queued then popped back to back.
    out_ready = 1'b0;
    in_valid = 1'b1; in_addr = 32'h0;
    in_cmd = 4'd1; step();
    in_cmd = 4'd2; step();
    in_cmd = 4'd8; step();
    in_cmd = 4'd0; step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("clr_seq_class_wr", 32'(out_class), 0);
    step();
    check("clr_seq_wr_cnt", 32'(wr_cnt), 2);
    check("clr_seq_class_if", 32'(out_class), 1);
    step();
    check("clr_seq_if_cnt", 32'(if_cnt), 2);
    check("clr_seq_head_clr", 32'(out_cmd), 8);
    check("clr_seq_class_clr", 32'(out_class), 3);
    in_valid = 1'b1; in_cmd = 4'd7;    // illegal on the CLR pop edge: clear wins
    step();
    in_valid = 1'b0;
    check("clr_all_zero", {16'(rd_cnt | wr_cnt), 16'(if_cnt | bad_cnt)}, 0);
    step();
    check("clr_final_rd", 32'(rd_cnt), 1);
    check("clr_final_wr", 32'(wr_cnt), 0);
    check("clr_final_if", 32'(if_cnt), 0);

    // Steady state at two entries with push and pop every cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_cmd = 4'd9;
    in_addr = 32'd0; step();
    in_addr = 32'd1; step();
    check("ss_fill_start", 32'(fill_level), 2);
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_addr = 32'(j + 2);
      check($sformatf("ss_off%0d", j), 32'(out_offset), 32'(j));
      step();
      check($sformatf("ss_fill%0d", j), 32'(fill_level), 2);
    end
    in_valid = 1'b0;
    check("ss_rd_cnt", 32'(rd_cnt), 1);

    // Reset with three entries queued.
    out_ready = 1'b0;
    in_valid = 1'b1; in_addr = 32'd12; step();
    in_valid = 1'b0;
    check("mid_fill3", 32'(fill_level), 3);
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    check("mid_rst_fill",      32'(fill_level), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_in_ready",  32'(in_ready), 1);
    check("mid_rst_counters",  {16'(rd_cnt | wr_cnt), 16'(if_cnt | bad_cnt)}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
